inst_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the warp scheduler. Owns the fetch PC, issues

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_fifo.sv | 55 +++++
 rtl/inst_fetch_unit.sv | 107 ++++++++++
 tb/tb_inst_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared widths, fetch phase type and clog2 helper
package inst_fetch_unit_pkg;

  localparam int INSTMEM_ADDR_WIDTH = 16;
  localparam int INST_LENGTH        = 32;

  // RUN: normal issue/buffer; DRAIN: stale responses from before a redirect still arriving
  typedef enum logic {
    PH_RUN   = 1'b0,
    PH_DRAIN = 1'b1
  } phase_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// rtl/inst_fetch_unit_fifo.sv - registered instruction buffer with flush, no bypass
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer/occupancy update; flush empties the buffer and wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, credit-limited imem reads, redirect flush/drain
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = INSTMEM_ADDR_WIDTH,
  parameter int INST_W = INST_LENGTH,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_addr,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_W-1:0]     imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_W-1:0]     imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst,
  output logic [ADDR_W-1:0]     inst_pc,
  output logic [clog2(DEPTH):0] outstanding
);

  localparam int CW = clog2(DEPTH) + 1;

  phase_t                   phase;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        rsp_pc;
  logic [CW-1:0]            drop_cnt;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            rsp_left;
  logic [CW:0]              credit_used;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [INST_W+ADDR_W-1:0] head;

  // Buffered plus in-flight reads (dropped ones included) must stay below DEPTH
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = reset && !halt && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;

  assign drop     = (phase == PH_DRAIN);
  assign push     = imem_rsp_valid && !drop && !redirect;
  assign pop      = inst_valid && inst_ready && !redirect;
  assign rsp_left = outstanding - CW'(imem_rsp_valid);

  assign inst_valid      = !fifo_empty;
  assign {inst, inst_pc} = head;

  // Reads issued but not yet answered, net of same-cycle issue and response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) outstanding <= '0;
    else        outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
  end

  // PCs, drop counter and RUN/DRAIN phase; redirect reloads everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= PH_RUN;
      fetch_pc <= '0;
      rsp_pc   <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
      rsp_pc   <= redirect_addr;
      drop_cnt <= rsp_left;
      phase    <= (rsp_left != '0) ? PH_DRAIN : PH_RUN;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 1'b1;
      if (imem_rsp_valid) begin
        if (drop) begin
          drop_cnt <= drop_cnt - 1'b1;
          if (drop_cnt == CW'(1)) phase <= PH_RUN;
        end else begin
          rsp_pc <= rsp_pc + 1'b1;
        end
      end
    end
  end

  // The credit limit makes an overflowing push impossible
  assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full && !pop));

  inst_fetch_unit_fifo #(
    .WIDTH (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench against a queue-based fetch reference model
module tb_inst_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic [2:0]  outstanding;

  inst_fetch_unit #(.ADDR_W(16), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        flight[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;
  int          cyc;
  int          checks;
  int          errors;

  int          p_halt, p_redir, p_ready, p_pop, lat_min, lat_max;
  logic [15:0] redir_fixed;
  bit          redir_rand;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a + 16'h1234};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_mode(input int h, input int r, input int rdy, input int pp,
                          input int lmin, input int lmax, input logic [15:0] ra, input bit rr);
    p_halt = h; p_redir = r; p_ready = rdy; p_pop = pp;
    lat_min = lmin; lat_max = lmax; redir_fixed = ra; redir_rand = rr;
  endtask

  task automatic model_cycle();
    bit   exp_req;
    bit   consume;
    req_t r;
    int   due;
    exp_req = !halt && !redirect && ((exp_q.size() + flight.size()) < DEPTH);
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check_eq("req_addr", 32'(imem_req_addr), 32'(exp_pc));
    check_eq("outstanding", 32'(outstanding), 32'(flight.size()));
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
      check_eq("inst", inst, mem_word(exp_q[0]));
    end
    consume = (exp_q.size() > 0) && inst_ready && !redirect;
    if (redirect) begin
      foreach (flight[i]) flight[i].stale = 1'b1;
      exp_q.delete();
    end
    if (consume) void'(exp_q.pop_front());
    if (imem_rsp_valid) begin
      r = flight.pop_front();
      if (!r.stale) exp_q.push_back(r.addr);
    end
    if (exp_req && imem_req_ready) begin
      due = cyc + 1 + int'($urandom_range(lat_max, lat_min));
      flight.push_back('{exp_pc, due, 1'b0});
      exp_pc = exp_pc + 16'd1;
    end
    if (redirect) exp_pc = redirect_addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    halt           = ($urandom_range(99) < p_halt);
    redirect       = ($urandom_range(99) < p_redir);
    redirect_addr  = redir_rand ? 16'($urandom) : redir_fixed;
    imem_req_ready = ($urandom_range(99) < p_ready);
    inst_ready     = ($urandom_range(99) < p_pop);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (flight.size() > 0) begin
      if (flight[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(flight[0].addr);
      end
    end
    @(negedge clk);
    model_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_pc = '0;
    set_mode(0, 0, 100, 100, 0, 0, 16'h0, 1'b0);

    @(negedge clk);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_outstanding", 32'(outstanding), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // streaming with zero-latency memory
    set_mode(0, 0, 100, 100, 0, 0, 16'h0, 1'b0);
    run(40);

    // consumer stalled: buffer fills, then one pop frees one credit
    set_mode(0, 0, 100, 0, 3, 3, 16'h0, 1'b0);
    run(20);
    check_eq("full_outstanding", 32'(outstanding), 32'd0);
    check_eq("full_inst_valid", 32'(inst_valid), 32'd1);
    set_mode(0, 0, 100, 100, 3, 3, 16'h0, 1'b0);
    run(1);
    set_mode(0, 0, 100, 0, 3, 3, 16'h0, 1'b0);
    run(10);

    // redirect to 0x0100 with reads in flight
    set_mode(0, 0, 100, 100, 3, 3, 16'h0, 1'b0);
    run(4);
    set_mode(0, 100, 100, 100, 3, 3, 16'h0100, 1'b0);
    run(1);
    set_mode(0, 0, 100, 100, 3, 3, 16'h0, 1'b0);
    run(20);

    // random redirects colliding with responses and pops
    set_mode(10, 15, 70, 60, 0, 4, 16'h0, 1'b1);
    run(600);

    // PC wrap-around
    set_mode(0, 100, 100, 100, 0, 2, 16'hFFFE, 1'b0);
    run(1);
    set_mode(0, 0, 100, 100, 0, 2, 16'h0, 1'b0);
    run(20);

    // halt with random request stalls
    set_mode(40, 0, 50, 70, 0, 3, 16'h0, 1'b0);
    run(400);

    // async reset in the middle of a burst
    set_mode(0, 0, 100, 100, 2, 2, 16'h0, 1'b0);
    run(6);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("midrst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("midrst_outstanding", 32'(outstanding), 32'd0);
    check_eq("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    halt = 1'b0; redirect = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; inst_ready = 1'b0;
    flight.delete(); exp_q.delete(); exp_pc = '0;
    @(negedge clk);
    reset = 1'b1;

    // resume after reset
    set_mode(10, 5, 80, 70, 0, 3, 16'h0, 1'b1);
    run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
